// File: rtl/ultrasonic_scan_scheduler.sv
// rtl/ultrasonic_scan_scheduler.sv - round-robin trigger/echo scheduler for HC-SR04-class rangers
// One sensor is fired at a time; its echo is timed and the result handed off before a crosstalk hold-off.
module ultrasonic_scan_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = 1000,
  parameter int ECHO_TIMEOUT   = 3800000,
  parameter int HOLDOFF_CYCLES = 6000000,
  parameter int WIDTH_W        = 22,
  localparam int ID_W          = $clog2(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trigger,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ID_W-1:0]      result_id,
  output logic [WIDTH_W-1:0]   result_width,
  output logic                 result_timeout,
  output logic                 busy
);

  localparam int PH_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]      TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]      HOLD_LAST = PH_W'(HOLDOFF_CYCLES - 1);
  localparam logic [WIDTH_W-1:0]   ECHO_MAX  = WIDTH_W'(ECHO_TIMEOUT);
  localparam logic [WIDTH_W-1:0]   ECHO_LAST = WIDTH_W'(ECHO_TIMEOUT - 1);
  localparam logic [N_SENSORS-1:0] ONE_HOT0  = N_SENSORS'(1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, HOLDOFF} stateT;

  stateT                state, nextState;
  logic [ID_W-1:0]      ptr, pick;
  logic [PH_W-1:0]      phaseCnt;
  logic [WIDTH_W-1:0]   echoCnt;
  logic [N_SENSORS-1:0] echoMeta, echoSync, echoPrev;
  logic [N_SENSORS-1:0] rotMask, shifted;
  int                   pickOff, pickSum;
  logic                 go, selEcho, rise;

  assign go      = enable && (|sensor_mask);
  assign selEcho = echoSync[ptr];
  assign rise    = selEcho && !echoPrev[ptr];
  assign busy    = (state != IDLE);

  // Rotate the mask so bit 0 is the sensor just after the pointer, then take the lowest set bit.
  always_comb begin
    rotMask = N_SENSORS'({sensor_mask, sensor_mask} >> (int'(ptr) + 1));
    shifted = '0;
    pickOff = 0;
    for (int j = N_SENSORS - 1; j >= 0; j--) begin
      shifted = rotMask >> j;
      if (shifted[0]) pickOff = j;
    end
    pickSum = int'(ptr) + 1 + pickOff;
    if (pickSum >= N_SENSORS) pickSum = pickSum - N_SENSORS;
    pick = ID_W'(pickSum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echoMeta <= '0;
      echoSync <= '0;
      echoPrev <= '0;
    end else begin
      echoMeta <= echo;
      echoSync <= echoMeta;
      echoPrev <= echoSync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (go) nextState = TRIG;
      TRIG:      if (phaseCnt == TRIG_LAST) nextState = WAIT_RISE;
      WAIT_RISE: begin
        if (rise)                         nextState = MEASURE;
        else if (echoCnt == ECHO_LAST)    nextState = REPORT;
      end
      MEASURE:   if (!selEcho || echoCnt == ECHO_MAX) nextState = REPORT;
      REPORT:    if (result_ready) nextState = HOLDOFF;
      HOLDOFF:   if (phaseCnt == HOLD_LAST) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger        <= '0;
      ptr            <= ID_W'(N_SENSORS - 1);
      phaseCnt       <= '0;
      echoCnt        <= '0;
      result_valid   <= 1'b0;
      result_id      <= '0;
      result_width   <= '0;
      result_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          ptr      <= pick;
          trigger  <= ONE_HOT0 << pick;
          phaseCnt <= '0;
        end
        TRIG: begin
          if (phaseCnt == TRIG_LAST) begin
            trigger <= '0;
            echoCnt <= '0;
          end else begin
            phaseCnt <= phaseCnt + PH_W'(1);
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            echoCnt <= WIDTH_W'(1);
          end else if (echoCnt == ECHO_LAST) begin
            result_valid   <= 1'b1;
            result_id      <= ptr;
            result_width   <= '0;
            result_timeout <= 1'b1;
          end else begin
            echoCnt <= echoCnt + WIDTH_W'(1);
          end
        end
        MEASURE: begin
          // A falling echo wins over saturation when both happen on the same cycle.
          if (!selEcho) begin
            result_valid   <= 1'b1;
            result_id      <= ptr;
            result_width   <= echoCnt;
            result_timeout <= 1'b0;
          end else if (echoCnt == ECHO_MAX) begin
            result_valid   <= 1'b1;
            result_id      <= ptr;
            result_width   <= ECHO_MAX;
            result_timeout <= 1'b1;
          end else begin
            echoCnt <= echoCnt + WIDTH_W'(1);
          end
        end
        REPORT: if (result_ready) begin
          result_valid <= 1'b0;
          phaseCnt     <= '0;
        end
        HOLDOFF: phaseCnt <= phaseCnt + PH_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// tb/tb_ultrasonic_scan_scheduler.sv - directed plus randomized bench for ultrasonic_scan_scheduler
// A sensor model answers each trigger; a round-robin model predicts which sensor fires and what it reports.
module tb_ultrasonic_scan_scheduler;
  localparam int N = 4, TRIG = 10, TO = 100, HOLD = 20, WW = 22;

  logic          clk = 1'b0, rst_n = 1'b1, enable = 1'b0, result_ready = 1'b1;
  logic [N-1:0]  sensor_mask = '0, echo = '0, trigger;
  logic          result_valid, result_timeout, busy;
  logic [1:0]    result_id;
  logic [WW-1:0] result_width;

  ultrasonic_scan_scheduler #(.N_SENSORS(N), .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT(TO),
                              .HOLDOFF_CYCLES(HOLD), .WIDTH_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_mask(sensor_mask), .echo(echo),
    .trigger(trigger), .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_width(result_width), .result_timeout(result_timeout),
    .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkIn(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Sensor model: after a trigger falls, echo rises dly cycles later and stays high len cycles.
  int       cfgLen[N], cfgDly[N], actLen[N], actDly[N], tSince[N];
  int       curSel = -1;
  bit       noiseOn = 1'b0;
  int       riseQ[$], riseVecQ[$], fallQ[$];
  logic [N-1:0] prevTrig = '0;

  initial begin : sensorModel
    for (int s = 0; s < N; s++) begin
      tSince[s] = -1; cfgLen[s] = 0; cfgDly[s] = 1;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int s = 0; s < N; s++) tSince[s] = -1;
        echo = '0; curSel = -1; prevTrig = '0;
        riseQ.delete(); riseVecQ.delete(); fallQ.delete();
      end else begin
        if (trigger != '0 && prevTrig == '0) begin
          riseQ.push_back(cyc); riseVecQ.push_back(int'(trigger));
        end
        if (trigger == '0 && prevTrig != '0) fallQ.push_back(cyc);
        for (int s = 0; s < N; s++) begin
          if (trigger[s] && !prevTrig[s]) curSel = s;
          if (prevTrig[s] && !trigger[s]) begin
            tSince[s] = 0; actLen[s] = cfgLen[s]; actDly[s] = cfgDly[s];
          end else if (tSince[s] >= 0) begin
            tSince[s]++;
          end
          if (tSince[s] >= 0) begin
            echo[s] = (tSince[s] >= actDly[s]) && (tSince[s] < actDly[s] + actLen[s]);
            if (tSince[s] >= actDly[s] + actLen[s]) tSince[s] = -1;
          end else if (noiseOn && s != curSel) begin
            echo[s] = 1'($urandom_range(0, 1));
          end else begin
            echo[s] = 1'b0;
          end
        end
        prevTrig = trigger;
      end
    end
  end

  int           modelPtr = N - 1;
  logic [N-1:0] modelMask = '0;
  int           hsCyc = 0;
  bit           haveHs = 1'b0;

  function automatic int modelPick();
    for (int i = 1; i <= N; i++) begin
      int s;
      s = (modelPtr + i) % N;
      if (modelMask[s]) return s;
    end
    return -1;
  endfunction

  task automatic waitRise(output int rc, output int rv);
    int n = 0;
    while (riseQ.size() == 0 && n < 3000) begin @(negedge clk); n++; end
    checkIn("trigger_rise_seen", riseQ.size(), 1, 1000);
    rc = -1; rv = -1;
    if (riseQ.size() > 0) begin rc = riseQ.pop_front(); rv = riseVecQ.pop_front(); end
  endtask

  task automatic waitFall(output int fc);
    int n = 0;
    while (fallQ.size() == 0 && n < 3000) begin @(negedge clk); n++; end
    checkIn("trigger_fall_seen", fallQ.size(), 1, 1000);
    fc = -1;
    if (fallQ.size() > 0) fc = fallQ.pop_front();
  endtask

  task automatic waitValid(output int vc);
    int n = 0;
    while (result_valid !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    check("result_valid_seen", result_valid, 1);
    vc = cyc;
  endtask

  task automatic doMeas(input int len, input int dly, input int rdyWait, input bit dropEn);
    int expId, rc, rv, fc, vc;
    logic [1:0] idL; logic [WW-1:0] wL; logic toL;
    expId = modelPick(); modelPtr = expId;
    cfgLen[expId] = len; cfgDly[expId] = dly;
    if (rdyWait > 0) result_ready = 1'b0;
    waitRise(rc, rv);
    check("trigger_sensor", rv, 1 << expId);
    if (haveHs) check("holdoff_spacing", rc - hsCyc, HOLD + 2);
    waitFall(fc);
    check("trigger_width", fc - rc, TRIG);
    if (dropEn) enable = 1'b0;
    waitValid(vc);
    idL = result_id; wL = result_width; toL = result_timeout;
    check("result_id", idL, expId);
    if (len == 0) begin
      check("noecho_width", wL, 0);
      check("noecho_timeout", toL, 1);
      checkIn("noecho_latency", vc - fc, TO - 3, TO + 3);
    end else if (len > TO) begin
      check("long_width", wL, TO);
      check("long_timeout", toL, 1);
    end else begin
      checkIn("echo_width", int'(wL), len - 1, len + 1);
      check("echo_timeout", toL, 0);
      checkIn("valid_latency", vc - (fc + dly + len), 2, 4);
    end
    if (rdyWait > 0) begin
      for (int k = 0; k < rdyWait; k++) begin
        @(negedge clk);
        check("stall_hold", {result_valid, result_id, result_width, result_timeout},
              {1'b1, idL, wL, toL});
        check("stall_no_trigger", trigger, 0);
      end
      result_ready = 1'b1;
      hsCyc = cyc;
    end else begin
      hsCyc = vc;
    end
    haveHs = 1'b1;
    @(negedge clk);
    check("valid_after_handshake", result_valid, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_trigger", trigger, 0);
    check("rst_async_valid", result_valid, 0);
    check("rst_async_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    modelPtr = N - 1;
    haveHs = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int rc, rv, fc, vc, expId, pickLen;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {trigger, result_valid, result_id, result_width, result_timeout, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy_disabled", busy, 0);

    // Full mask, steady echoes: order 0,1,2,3,0
    modelMask = 4'hF; sensor_mask = 4'hF; enable = 1'b1;
    for (int i = 0; i < 5; i++) doMeas(40, 5, 0, 1'b0);

    // Sparse mask: only 1 and 3 alternate
    modelMask = 4'hA; sensor_mask = 4'hA;
    for (int i = 0; i < 4; i++) doMeas(40, 5, 0, 1'b0);

    // No echo on sensor 0, then an over-long echo, then back-pressure
    modelMask = 4'hF; sensor_mask = 4'hF;
    doMeas(0, 5, 0, 1'b0);
    doMeas(150, 5, 0, 1'b0);
    doMeas(40, 5, 0, 1'b0);
    doMeas(40, 5, 50, 1'b0);
    doMeas(40, 5, 0, 1'b0);

    // Enable dropped mid-measurement: finish, then stay idle
    doMeas(30, 5, 0, 1'b1);
    repeat (60) @(negedge clk);
    check("disabled_busy", busy, 0);
    check("disabled_no_rise", riseQ.size(), 0);

    // Enabled with empty mask
    sensor_mask = 4'h0; enable = 1'b1;
    repeat (40) @(negedge clk);
    check("empty_mask_busy", busy, 0);
    check("empty_mask_no_rise", riseQ.size(), 0);
    modelMask = 4'hF; sensor_mask = 4'hF; haveHs = 1'b0;

    // Randomized lengths, delays, masks, stalls, and noise on idle channels
    noiseOn = 1'b1;
    for (int r = 0; r < 16; r++) begin
      if (r % 4 == 3) begin
        modelMask = 4'($urandom_range(1, 15)); sensor_mask = modelMask;
      end
      case ($urandom_range(0, 3))
        0:       pickLen = 0;
        3:       pickLen = $urandom_range(120, 160);
        default: pickLen = $urandom_range(5, 80);
      endcase
      doMeas(pickLen, $urandom_range(1, 30), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0, 1'b0);
    end
    noiseOn = 1'b0;
    modelMask = 4'hF; sensor_mask = 4'hF;

    // Reset during MEASURE
    expId = modelPick(); modelPtr = expId;
    cfgLen[expId] = 60; cfgDly[expId] = 5;
    waitRise(rc, rv);
    waitFall(fc);
    repeat (20) @(negedge clk);
    check("busy_in_measure", busy, 1);
    pulseReset();
    doMeas(40, 5, 0, 1'b0);

    // Reset during TRIG
    waitRise(rc, rv);
    check("trigger_before_reset", trigger, 1 << 1);
    pulseReset();
    doMeas(40, 5, 0, 1'b0);

    // Reset while a result is pending
    expId = modelPick(); modelPtr = expId;
    cfgLen[expId] = 30; cfgDly[expId] = 5;
    result_ready = 1'b0;
    waitRise(rc, rv);
    waitFall(fc);
    waitValid(vc);
    pulseReset();
    result_ready = 1'b1;
    doMeas(40, 5, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ultrasonic_scan_scheduler.md
# ultrasonic_scan_scheduler

Round-robin scheduler that time-shares the ultrasonic ranging channel across up to N HC-SR04-class sensors. For each enabled sensor in turn it issues the 10 us trigger pulse, times the returned echo pulse, and reports the result through a valid/ready handshake. It then enforces a crosstalk hold-off before firing the next sensor. It sits between the sensor pins and the distance-conversion/display logic, and replaces per-sensor free-running trigger generators.

## Interface
- N_SENSORS, 4: number of sensor channels (2..8).
- TRIG_CYCLES, 1000: trigger high time in clk cycles (10 us at 100 MHz).
- ECHO_TIMEOUT, 3800000: maximum wait for echo rise, and maximum echo width, in cycles (38 ms).
- HOLDOFF_CYCLES, 6000000: dead time between the end of one measurement and the next trigger (60 ms).
- WIDTH_W, 22: width of result_width; must hold ECHO_TIMEOUT.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- enable  in  1  scan enable. Sampled only in IDLE.
- sensor_mask  in  N_SENSORS  1 = sensor participates. Sampled only in IDLE.
- echo  in  N_SENSORS  raw echo pins. Asynchronous; each bit is synchronised with 2 flops.
- trigger  out  N_SENSORS  trigger pins, registered. At most one bit is high at any time.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_id  out  clog2(N_SENSORS)  index of the sensor measured.
- result_width  out  WIDTH_W  echo high time in cycles.
- result_timeout  out  1  no echo, or echo too long.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset values: trigger=0, result_valid=0, result_id=0, result_width=0, result_timeout=0, busy=0, state=IDLE. The round-robin pointer resets to N_SENSORS-1, so the first pick is the lowest enabled index.
- IDLE: if enable && |sensor_mask, select the first set mask bit strictly after the pointer (wrapping), update the pointer, and go to TRIG. Otherwise stay in IDLE.
- TRIG: trigger[sel]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. Clear the timeout counter.
- WAIT_RISE: wait for a rising edge on synchronised echo[sel] (previous sample 0, current sample 1), then go to MEASURE with the width counter at 1.
  - If the counter reaches ECHO_TIMEOUT first, go to REPORT with width=0 and timeout=1.
  - An echo already high on entry does not count as an edge.
- MEASURE: increment the width counter each cycle while synchronised echo[sel]=1.
  - On fall: go to REPORT with width=count and timeout=0.
  - If count reaches ECHO_TIMEOUT: go to REPORT with width=ECHO_TIMEOUT and timeout=1. The counter saturates and never wraps.
- REPORT: result_valid=1. id, width and timeout are held stable until the cycle where result_valid && result_ready, then go to HOLDOFF. Back-pressure stalls the scan indefinitely.
- HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE.
- Echo activity on non-selected channels is ignored.
- Deasserting enable mid-measurement does not abort: the current sequence completes through HOLDOFF, and no new trigger is issued.
- mask=0 with enable=1: stay in IDLE, busy=0.
- rst_n assertion in any state:
  - trigger drops immediately, asynchronously.
  - result_valid clears.
  - The pointer resets.
  - A pending result is discarded.

## Timing
- IDLE decision at cycle t: trigger[sel] rises at t+1 and falls at t+1+TRIG_CYCLES.
- Echo-to-internal latency is 2 cycles. result_width equals the echo high time in cycles, ±1.
- result_valid rises 1 cycle after the internal echo fall is seen, i.e. 3 cycles after the pin falls.
- Handshake completes on the cycle result_valid && result_ready. result_valid is low on the next cycle.
- Minimum spacing between trigger rises of consecutive measurements = TRIG_CYCLES + echo phase + 1 (REPORT, ready held high) + HOLDOFF_CYCLES + 1 (IDLE).
- Each counter must be sized to clog2 of its largest parameter.

## Test plan
Use parameters N_SENSORS=4, TRIG_CYCLES=10, ECHO_TIMEOUT=100, HOLDOFF_CYCLES=20 for all scenarios.
- Reset, then enable=1, mask=4'b1111, ready=1, each sensor echoes 40 cycles high 5 cycles after its trigger falls:
  - Triggers fire in order 0,1,2,3,0.
  - Each trigger pulse is exactly 10 cycles, with one-hot trigger.
  - Results are id 0..3 with width 40±1 and timeout=0.
- mask=4'b1010: only sensors 1 and 3 alternate, and triggers 0 and 2 never assert.
- No echo on sensor 0: result is id=0, width=0, timeout=1, with result_valid 100±3 cycles after trigger falls.
- Echo held high 150 cycles: result is width=100, timeout=1, and the next trigger still honours the 20-cycle hold-off.
- ready=0 for 50 cycles in REPORT:
  - result_valid, id and width stay stable.
  - No trigger asserts.
  - After ready=1 the handshake completes and the next trigger rises 20+1+1 cycles later.
- rst_n pulsed low during MEASURE:
  - trigger=0 and result_valid=0 asynchronously.
  - After release with enable=1, the first trigger goes to sensor 0.
